// File: rtl/isi_channel_ocm_fir_if.sv
// Bus bundle for the ISI channel model: symbol stream in and out, plus the
// pulse-response load port that the on-chip memory feeds.
interface isi_channel_ocm_fir_if #(
  parameter int W = 8
);
  logic signed [W-1:0] signal_in;
  logic                signal_in_valid;
  logic signed [W-1:0] signal_out;
  logic                signal_out_valid;
  logic                load_mem;
  logic                done_wait;
  logic [7:0]          location;
  logic [63:0]         mem_data;

  // Parent side: symbol source and pulse-response memory.
  modport master (
    output signal_in, signal_in_valid, load_mem, location, mem_data,
    input  signal_out, signal_out_valid, done_wait
  );

  // Channel model side.
  modport slave (
    input  signal_in, signal_in_valid, load_mem, location, mem_data,
    output signal_out, signal_out_valid, done_wait
  );
endinterface

// File: rtl/isi_channel_ocm_fir.sv
// Inter-symbol-interference channel model. Captures one symbol-spaced tap per
// symbol period out of an oversampled pulse response streamed in as 64-bit
// words, then convolves the symbol stream with those taps (Q1.7, saturated).
module isi_channel_ocm_fir #(
  parameter int PULSE_RESPONSE_LENGTH = 3,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int SYMBOL_SEPERATION     = 56
) (
  input logic                  clk,
  input logic                  rstn,
  isi_channel_ocm_fir_if.slave bus
);
  localparam int L         = PULSE_RESPONSE_LENGTH;
  localparam int W         = SIGNAL_RESOLUTION;
  localparam int SS        = SYMBOL_SEPERATION;
  localparam int LAST_WORD = ((L - 1) * SS) / 8;
  localparam int ACC_W     = 2 * W + 2;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  logic signed [W-1:0] tap_q [L];
  logic signed [W-1:0] tap_d [L];
  logic signed [W-1:0] x_q   [L];
  logic signed [W-1:0] x_d   [L];
  logic signed [W-1:0] x_new [L];
  logic signed [W-1:0] signal_out_q, signal_out_d;
  logic                signal_out_valid_q, signal_out_valid_d;
  logic                done_wait_q, done_wait_d;

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic                    fire;

  // Next-state logic: tap capture during load, then shift/convolve per valid symbol.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    tap_d              = tap_q;
    x_d                = x_q;
    signal_out_d       = signal_out_q;
    signal_out_valid_d = 1'b0;
    done_wait_d        = done_wait_q;
    prod               = '0;
    acc                = '0;

    // Capture: pick byte (k*SS)%8 of the word holding sample k*SS.
    if (bus.load_mem && !done_wait_q) begin
      for (int k = 0; k < L; k++) begin
        for (int j = 0; j < 8; j++) begin
          if (int'(bus.location) == (k * SS) / 8 && j == (k * SS) % 8) begin
            tap_d[k] = bus.mem_data[8*j +: W];
          end
        end
      end
      if (int'(bus.location) == LAST_WORD) begin
        done_wait_d = 1'b1;
      end
    end

    // Post-shift history: the current symbol is the cursor.
    x_new[0] = bus.signal_in;
    for (int k = 1; k < L; k++) begin
      x_new[k] = x_q[k-1];
    end

    for (int k = 0; k < L; k++) begin
      prod = tap_q[k] * x_new[k];
      acc  = acc + ACC_W'(prod);
    end
    shifted = acc >>> (W - 1);

    fire = bus.signal_in_valid && done_wait_q;
    if (fire) begin
      x_d                = x_new;
      signal_out_valid_d = 1'b1;
      if (shifted > SAT_HI) begin
        signal_out_d = SAT_HI[W-1:0];
      end else if (shifted < SAT_LO) begin
        signal_out_d = SAT_LO[W-1:0];
      end else begin
        signal_out_d = shifted[W-1:0];
      end
    end
  end

  // State registers; taps and history are cleared so a reset forces a reload.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the small tap/history arrays are flops, not RAM, so clearing them on reset is cheap and required.
      for (int k = 0; k < L; k++) begin
        tap_q[k] <= '0;
        x_q[k]   <= '0;
      end
      signal_out_q       <= '0;
      signal_out_valid_q <= 1'b0;
      done_wait_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      tap_q              <= tap_d;
      x_q                <= x_d;
      signal_out_q       <= signal_out_d;
      signal_out_valid_q <= signal_out_valid_d;
      done_wait_q        <= done_wait_d;
    end
  end

  assign bus.signal_out       = signal_out_q;
  assign bus.signal_out_valid = signal_out_valid_q;
  assign bus.done_wait        = done_wait_q;
endmodule

// File: tb/tb_isi_channel_ocm_fir.sv
// Directed bench for the ISI channel model: tap load, impulse response,
// gating, freeze, floor rounding, async reset and saturation.
module tb_isi_channel_ocm_fir;
  logic clk;
  logic rstn;
  int   total;
  int   bad;

  isi_channel_ocm_fir_if #(.W(8)) bus ();

  isi_channel_ocm_fir dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int loc, input logic [63:0] data);
    bus.load_mem = 1'b1;
    bus.location = 8'(loc);
    bus.mem_data = data;
    tick();
    bus.load_mem = 1'b0;
  endtask

  // Full ascending load; tap words carry tN in byte 0, filler elsewhere.
  task automatic load_all(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
    logic [63:0] w;
    for (int i = 0; i <= 14; i++) begin
      w = 64'hA5C3_9E71_2B4D_6F55;
      if (i == 0)  w[7:0] = t0;
      if (i == 7)  w[7:0] = t1;
      if (i == 14) w[7:0] = t2;
      if (i == 14) check("done_before_last", int'(bus.done_wait), 0);
      load_word(i, w);
    end
  endtask

  task automatic send(input logic [7:0] s);
    bus.signal_in       = s;
    bus.signal_in_valid = 1'b1;
    tick();
    bus.signal_in_valid = 1'b0;
  endtask

  function automatic int sout();
    return int'(bus.signal_out);
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    #7;
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.signal_in       = '0;
    bus.signal_in_valid = 1'b0;
    bus.load_mem        = 1'b0;
    bus.location        = '0;
    bus.mem_data        = '0;
    rstn = 1'b0;
    #3;
    check("rst_done", int'(bus.done_wait), 0);
    check("rst_valid", int'(bus.signal_out_valid), 0);
    check("rst_out", sout(), 0);
    #10;
    rstn = 1'b1;
    tick();

    // Inputs before done_wait are dropped.
    send(8'h7F);
    check("gate_valid", int'(bus.signal_out_valid), 0);
    send(8'h40);
    check("gate_out", sout(), 0);

    // Partial load: word 0 gets a temporary tap value that the full load overwrites.
    for (int i = 0; i <= 4; i++) load_word(i, 64'h0000_0000_0000_0011);
    check("partial_done", int'(bus.done_wait), 0);
    load_word(20, 64'h0000_0000_0000_0077);
    check("beyond_lw_done", int'(bus.done_wait), 0);

    load_all(8'h40, 8'h20, 8'h10);
    check("done_after_last", int'(bus.done_wait), 1);

    // Loads after done must not change taps.
    load_word(0, 64'h0000_0000_0000_007F);
    load_word(14, 64'h0000_0000_0000_007F);
    check("done_sticky", int'(bus.done_wait), 1);

    // Impulse with an idle gap after the first sample.
    send(8'h7F);
    check("imp0_out", sout(), 63);
    check("imp0_valid", int'(bus.signal_out_valid), 1);
    bus.signal_in = 8'h11;
    tick();
    check("gap_valid", int'(bus.signal_out_valid), 0);
    check("gap_hold", sout(), 63);
    send(8'h00);
    check("imp1_out", sout(), 31);
    send(8'h00);
    check("imp2_out", sout(), 15);
    send(8'h00);
    check("imp3_out", sout(), 0);
    check("imp3_valid", int'(bus.signal_out_valid), 1);

    // Negative input: arithmetic shift floors toward -inf.
    send(8'hFF);
    check("neg0_out", sout(), -1);
    send(8'h00);
    check("neg1_out", sout(), -1);
    send(8'h00);
    check("neg2_out", sout(), -1);
    send(8'h00);
    check("neg3_out", sout(), 0);

    // Async reset mid-stream clears without a clock edge.
    send(8'h7F);
    check("pre_rst_out", sout(), 63);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_out", sout(), 0);
    check("arst_valid", int'(bus.signal_out_valid), 0);
    check("arst_done", int'(bus.done_wait), 0);
    #4;
    rstn = 1'b1;
    tick();
    send(8'h7F);
    check("post_rst_valid", int'(bus.signal_out_valid), 0);

    // Only the last word reloaded: taps 0 and 1 must still be cleared.
    load_word(14, 64'h0000_0000_0000_0010);
    check("lw_only_done", int'(bus.done_wait), 1);
    send(8'h7F);
    check("rtap0_out", sout(), 0);
    send(8'h00);
    check("rtap1_out", sout(), 0);
    send(8'h00);
    check("rtap2_out", sout(), 15);

    // Saturation with all taps 0x7F.
    do_reset();
    load_all(8'h7F, 8'h7F, 8'h7F);
    send(8'h7F);
    check("sat_p0", sout(), 126);
    send(8'h7F);
    check("sat_p1", sout(), 127);
    send(8'h7F);
    check("sat_p2", sout(), 127);
    send(8'h80);
    check("sat_n0", sout(), 125);
    send(8'h80);
    check("sat_n1", sout(), -128);
    send(8'h80);
    check("sat_n2", sout(), -128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
